// File: rtl/arith_op_controller.sv
// Request/response controller for the 16-bit arithmetic unit: issues one op at a time,
// waits the unit's fixed latency, and returns the captured result with the request tag.
module arith_op_controller #(
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned TAG_WIDTH     = 4,
   parameter int unsigned ARITH_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_fun,
   input  logic [DATA_WIDTH-1:0] req_a,
   input  logic [DATA_WIDTH-1:0] req_b,
   input  logic [TAG_WIDTH-1:0]  req_tag,
   output logic [DATA_WIDTH-1:0] in1,
   output logic [DATA_WIDTH-1:0] in2,
   output logic [1:0]            arith_fun,
   output logic                  arith_en,
   input  logic [DATA_WIDTH-1:0] arith_out,
   input  logic                  arith_cout,
   input  logic                  arith_flag,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_cout,
   output logic                  rsp_err,
   output logic [TAG_WIDTH-1:0]  rsp_tag,
   output logic [15:0]           op_count
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t                state_q, state_d;
   logic [1:0]            fun_q, fun_d;
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [TAG_WIDTH-1:0]  tag_q, tag_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  rsp_cout_q, rsp_cout_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  flag_q, flag_d;
   logic [15:0]           op_count_q, op_count_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         fun_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         tag_q      <= '0;
         cnt_q      <= '0;
         rsp_data_q <= '0;
         rsp_cout_q <= 1'b0;
         rsp_err_q  <= 1'b0;
         flag_q     <= 1'b0;
         op_count_q <= '0;
      end else begin
         state_q    <= state_d;
         fun_q      <= fun_d;
         a_q        <= a_d;
         b_q        <= b_d;
         tag_q      <= tag_d;
         cnt_q      <= cnt_d;
         rsp_data_q <= rsp_data_d;
         rsp_cout_q <= rsp_cout_d;
         rsp_err_q  <= rsp_err_d;
         flag_q     <= flag_d;
         op_count_q <= op_count_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fun_d      = fun_q;
      a_d        = a_q;
      b_d        = b_q;
      tag_d      = tag_q;
      cnt_d      = cnt_q;
      rsp_data_d = rsp_data_q;
      rsp_cout_d = rsp_cout_q;
      rsp_err_d  = rsp_err_q;
      flag_d     = flag_q;
      op_count_d = op_count_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               fun_d = req_fun;
               a_d   = req_a;
               b_d   = req_b;
               tag_d = req_tag;
               // Divide-by-zero is answered locally; the unit never sees it.
               if (req_fun == 2'b11 && req_b == '0) begin
                  rsp_data_d = '1;
                  rsp_cout_d = 1'b0;
                  rsp_err_d  = 1'b1;
                  state_d    = S_RESP;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            cnt_d   = 4'(ARITH_LATENCY - 1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               rsp_data_d = arith_out;
               rsp_cout_d = arith_cout;
               rsp_err_d  = 1'b0;
               flag_d     = arith_flag;
               state_d    = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
               if (op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state_q == S_IDLE);
      arith_en  = (state_q == S_ISSUE);
      rsp_valid = (state_q == S_RESP);
   end

   assign in1       = a_q;
   assign in2       = b_q;
   assign arith_fun = fun_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_cout  = rsp_cout_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_tag   = tag_q;
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_arith_op_controller.sv
// Scoreboard bench for arith_op_controller driving a behavioural arithmetic unit of latency LAT.
module tb_arith_op_controller;

   localparam int unsigned LAT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [1:0]  req_fun;
   logic [15:0] req_a, req_b;
   logic [3:0]  req_tag;
   logic [15:0] in1, in2;
   logic [1:0]  arith_fun;
   logic        arith_en;
   logic [15:0] arith_out;
   logic        arith_cout, arith_flag;
   logic        rsp_valid, rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_cout, rsp_err;
   logic [3:0]  rsp_tag;
   logic [15:0] op_count;

   arith_op_controller #(.DATA_WIDTH(16), .TAG_WIDTH(4), .ARITH_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_fun(req_fun),
      .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
      .in1(in1), .in2(in2), .arith_fun(arith_fun), .arith_en(arith_en),
      .arith_out(arith_out), .arith_cout(arith_cout), .arith_flag(arith_flag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_cout(rsp_cout), .rsp_err(rsp_err), .rsp_tag(rsp_tag), .op_count(op_count)
   );

   always #5 clk = ~clk;

   // Unit model: result appears LAT edges after arith_en is sampled, garbage otherwise.
   function automatic logic [17:0] unit_f(input logic [1:0] f, input logic [15:0] x, input logic [15:0] y);
      logic [16:0] s;
      logic [31:0] p;
      logic [15:0] o;
      logic        c;
      case (f)
         2'b00: begin s = {1'b0, x} + {1'b0, y}; o = s[15:0]; c = s[16]; end
         2'b01: begin o = x - y; c = (x < y); end
         2'b10: begin p = x * y; o = p[15:0]; c = |p[31:16]; end
         default: begin o = (y != 16'd0) ? x / y : 16'hFFFF; c = 1'b0; end
      endcase
      return {(o == 16'd0), c, o};
   endfunction

   logic [17:0]    pd [0:LAT-1];
   logic [LAT-1:0] pv = '0;
   always @(posedge clk) begin
      pv    <= {pv[LAT-2:0], arith_en};
      pd[0] <= unit_f(arith_fun, in1, in2);
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
   end
   assign arith_out  = pv[LAT-1] ? pd[LAT-1][15:0] : 16'hBAD0;
   assign arith_cout = pv[LAT-1] ? pd[LAT-1][16]   : 1'b0;
   assign arith_flag = pv[LAT-1] ? pd[LAT-1][17]   : 1'b0;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] d;
      logic        c;
      logic        e;
      logic [3:0]  t;
      int unsigned acc_edge;
   } exp_t;
   exp_t sb[$];

   int unsigned total = 0;
   int unsigned bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: latency on rsp_valid rise, contents and arith_en pulse count on retire.
   logic        prev_v = 1'b0;
   int unsigned en_cnt = 0;
   always @(negedge clk) begin
      if (!rst) begin
         prev_v = 1'b0;
         en_cnt = 0;
      end else begin
         if (arith_en) en_cnt++;
         if (rsp_valid && !prev_v) begin
            if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
            else chk("latency", cyc, sb[0].e ? sb[0].acc_edge : sb[0].acc_edge + LAT + 1);
         end
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) chk("retire_no_exp", 1, 0);
            else begin
               exp_t x;
               x = sb.pop_front();
               chk("rsp_data", rsp_data, x.d);
               chk("rsp_cout", rsp_cout, x.c);
               chk("rsp_err",  rsp_err,  x.e);
               chk("rsp_tag",  rsp_tag,  x.t);
               chk("arith_en_pulses", en_cnt, x.e ? 0 : 1);
            end
            en_cnt = 0;
         end
         prev_v = rsp_valid;
      end
   end

   task automatic do_req(input logic [1:0] f, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] t, input logic [15:0] ed, input logic ec,
                         input logic ee, input bit drop);
      exp_t x;
      bit   ok = 1'b0;
      req_valid = 1'b1; req_fun = f; req_a = a; req_b = b; req_tag = t;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (req_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("req_accept_timeout", 0, 1);
      x.d = ed; x.c = ec; x.e = ee; x.t = t; x.acc_edge = cyc + 1;
      if (ok) sb.push_back(x);
      @(posedge clk); #1;
      if (drop) req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         chk("drain_timeout", sb.size(), 0);
         sb.delete();
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b0; req_valid = 1'b0; req_fun = '0; req_a = '0; req_b = '0; req_tag = '0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_arith_en", arith_en, 0);
      chk("rst_in1_in2_fun", {in1, in2, arith_fun}, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_fields", {rsp_data, rsp_cout, rsp_err, rsp_tag}, 0);
      chk("rst_op_count", op_count, 0);
      @(posedge clk); #1; rst = 1'b1;

      // add / sub / mul / div / negative sub
      do_req(2'b00, 16'd17,  16'd12,  4'd3, 16'd29,    1'b0, 1'b0, 1'b1);
      drain(); chk("op_count_t1", op_count, 1);
      do_req(2'b01, 16'd17,  16'd12,  4'd5, 16'd5,     1'b0, 1'b0, 1'b1);
      do_req(2'b10, 16'd300, 16'd300, 4'd6, 16'd24464, 1'b1, 1'b0, 1'b1);
      do_req(2'b11, 16'd100, 16'd7,   4'd7, 16'd14,    1'b0, 1'b0, 1'b1);
      do_req(2'b01, 16'd12,  16'd17,  4'd8, 16'd65531, 1'b1, 1'b0, 1'b1);
      drain(); chk("op_count_mix", op_count, 5);

      // backpressure with a competing request held on the input
      rsp_ready = 1'b0;
      do_req(2'b00, 16'hFFFF, 16'd1, 4'd9, 16'd0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
      @(posedge clk); #1;
      req_valid = 1'b1; req_fun = 2'b00; req_a = 16'd1; req_b = 16'd1; req_tag = 4'd15;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_data", {rsp_data, rsp_cout}, {16'd0, 1'b1});
         chk("bp_req_ready", req_ready, 0);
      end
      @(posedge clk); #1;
      req_valid = 1'b0; rsp_ready = 1'b1;
      drain(); chk("op_count_bp", op_count, 6);

      // divide by zero
      do_req(2'b11, 16'd100, 16'd0, 4'd10, 16'hFFFF, 1'b0, 1'b1, 1'b1);
      drain(); chk("op_count_div0", op_count, 7);

      // reset during WAIT
      do_req(2'b00, 16'd5, 16'd6, 4'd11, 16'd11, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_req_ready", req_ready, 1);
      chk("mid_rst_arith", {arith_en, in1, in2, arith_fun}, 0);
      chk("mid_rst_rsp_tag", rsp_tag, 0);
      chk("mid_rst_op_count", op_count, 0);
      sb.delete();
      @(posedge clk); #1; rst = 1'b1;
      do_req(2'b00, 16'd5, 16'd6, 4'd12, 16'd11, 1'b0, 1'b0, 1'b1);
      drain(); chk("op_count_after_rst", op_count, 1);

      // back-to-back with valid held high
      do_req(2'b00, 16'd1,     16'd2,     4'd0, 16'd3,     1'b0, 1'b0, 1'b0);
      do_req(2'b00, 16'd100,   16'd200,   4'd1, 16'd300,   1'b0, 1'b0, 1'b0);
      do_req(2'b00, 16'd40000, 16'd30000, 4'd2, 16'd4464,  1'b1, 1'b0, 1'b0);
      do_req(2'b00, 16'hFFFF,  16'hFFFF,  4'd3, 16'd65534, 1'b1, 1'b0, 1'b1);
      drain(); chk("op_count_b2b", op_count, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
